// File: rtl/chr_reader_pkg.sv
// CHR read-port shared types: FSM encoding plus the byte-address to SRAM-word map
// used by both the boot loader and the PPU-side reader.
package chr_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  typedef struct packed {
    logic [19:0] word;
    logic        lane;
  } chr_loc_t;

  // Bit 3 picks the byte lane, so the two bit-planes of a tile row share one word.
  function automatic chr_loc_t chr_map(input logic [19:0] byte_addr);
    chr_loc_t loc;
    loc.word = {1'b0, byte_addr[19:4], byte_addr[2:0]};
    loc.lane = byte_addr[3];
    return loc;
  endfunction

  function automatic logic [15:0] chr_fmt(input logic [15:0] word, input logic pair,
                                          input logic lane);
    logic [15:0] res;
    if (pair) res = word;
    else      res = {8'h00, (lane ? word[15:8] : word[7:0])};
    return res;
  endfunction

endpackage

// File: rtl/chr_reader.sv
// PPU pattern fetch port on the CHR SRAM: miss = WAIT_CYCLES bus cycles then a 1-cycle ack,
// last-word hit acks the cycle after accept; the requester holds i_req until ack (no other backpressure).
module chr_reader
  import chr_reader_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_load_done,
  input  logic        i_req,
  input  logic [19:0] i_addr,
  input  logic        i_pair,
  output logic        o_ack,
  output logic [15:0] o_rdata,
  output logic [19:0] o_sram_addr,
  output logic [15:0] o_sram_wdata,
  input  logic [15:0] i_sram_rdata,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n,
  output logic        o_sram_ub_n,
  output logic        o_sram_lb_n
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  chr_loc_t    in_loc, req_loc;
  logic        req_pair;
  logic        buf_vld;
  logic [19:0] buf_tag;
  logic [15:0] buf_dat;
  logic        accept, hit, last;

  assign o_sram_wdata = 16'h0000;
  assign o_sram_we_n  = 1'b1;

  always_comb begin
    in_loc    = chr_map(i_addr);
    accept    = (state == IDLE) && i_req && i_load_done;
    hit       = buf_vld && (buf_tag == in_loc.word);
    last      = (cnt == LAST_CNT);
    state_nxt = state;
    if (!i_load_done) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = hit ? ACK : ACCESS;
        ACCESS:  if (last) state_nxt = ACK;
        ACK:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Pins are driven from the next state so the bus and ack line up with the FSM without extra delay.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_ack       <= 1'b0;
      o_sram_addr <= '0;
      o_sram_oe_n <= 1'b1;
      o_sram_ub_n <= 1'b1;
      o_sram_lb_n <= 1'b1;
    end else begin
      o_ack <= (state_nxt == ACK);
      if (state_nxt == ACCESS) begin
        o_sram_addr <= (state == IDLE) ? in_loc.word : req_loc.word;
        o_sram_oe_n <= 1'b0;
        o_sram_ub_n <= 1'b0;
        o_sram_lb_n <= 1'b0;
      end else begin
        o_sram_addr <= '0;
        o_sram_oe_n <= 1'b1;
        o_sram_ub_n <= 1'b1;
        o_sram_lb_n <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt      <= '0;
      req_loc  <= '0;
      req_pair <= 1'b0;
      o_rdata  <= '0;
      buf_vld  <= 1'b0;
      buf_tag  <= '0;
      buf_dat  <= '0;
    end else begin
      if (accept) begin
        cnt      <= '0;
        req_loc  <= in_loc;
        req_pair <= i_pair;
        if (hit) o_rdata <= chr_fmt(buf_dat, i_pair, in_loc.lane);
      end else if (state == ACCESS) begin
        cnt <= cnt + 4'd1;
      end
      if (state == ACCESS && i_load_done && last) begin
        o_rdata <= chr_fmt(i_sram_rdata, req_pair, req_loc.lane);
        buf_vld <= 1'b1;
        buf_tag <= req_loc.word;
        buf_dat <= i_sram_rdata;
      end
      // Loss of load_done means SRAM contents may change under us.
      if (!i_load_done) buf_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chr_reader.sv
// Scoreboard bench for chr_reader: three instances (W = 2, 1, 15) on a shared clock,
// each reading a loader-packed SRAM model.
module tb_chr_reader;

  localparam int WV [3] = '{2, 1, 15};

  logic        clk;
  logic        rstn;
  logic [2:0]  done, req, pair, ack, oe_n, we_n, ub_n, lb_n;
  logic [19:0] addr [3];
  logic [19:0] sa   [3];
  logic [15:0] rdat [3];
  logic [15:0] wd   [3];
  logic [15:0] srd  [3];

  int tests = 0;
  int fails = 0;
  int oe_cnt   [3] = '{0, 0, 0};
  int ack_cnt  [3] = '{0, 0, 0};
  int addr_cnt [3] = '{0, 0, 0};

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];

  logic        bvld [3];
  logic [19:0] btag [3];
  logic [15:0] last_exp [3];

  function automatic logic [15:0] model_word(input logic [19:0] wa);
    logic [31:0] t;
    if (wa == 20'h00012) return 16'hA55A;
    t = {12'h0, wa} * 32'd40503;
    return t[15:0] ^ 16'h1234;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign srd[g] = oe_n[g] ? 16'hDEAD : model_word(sa[g]);
    chr_reader #(.WAIT_CYCLES(WV[g])) dut (
      .i_clk(clk), .i_rstn(rstn), .i_load_done(done[g]), .i_req(req[g]),
      .i_addr(addr[g]), .i_pair(pair[g]), .o_ack(ack[g]), .o_rdata(rdat[g]),
      .o_sram_addr(sa[g]), .o_sram_wdata(wd[g]), .i_sram_rdata(srd[g]),
      .o_sram_oe_n(oe_n[g]), .o_sram_we_n(we_n[g]), .o_sram_ub_n(ub_n[g]),
      .o_sram_lb_n(lb_n[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: bus strobe sanity every cycle, and scoreboard pop on every ack.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic ok;
      logic [15:0] e;
      logic have;
      if (!oe_n[k]) ok = !ub_n[k] && !lb_n[k];
      else          ok = ub_n[k] && lb_n[k] && (sa[k] == 20'h0);
      ok = ok && we_n[k] && (wd[k] == 16'h0);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL bus_strobes[%0d]: oe=%b ub=%b lb=%b we=%b addr=%h wd=%h", k,
                 oe_n[k], ub_n[k], lb_n[k], we_n[k], sa[k], wd[k]);
      end
      if (!oe_n[k]) oe_cnt[k]++;
      if (sa[k] != 20'h0) addr_cnt[k]++;
      if (ack[k]) begin
        ack_cnt[k]++;
        have = 1'b0;
        e = 16'h0;
        case (k)
          0: if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
          1: if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
          default: if (q2.size() > 0) begin have = 1'b1; e = q2.pop_front(); end
        endcase
        tests++;
        if (!have) begin
          fails++;
          $display("FAIL unexpected_ack[%0d]: got rdata %h expected no ack", k, rdat[k]);
        end else if (rdat[k] !== e) begin
          fails++;
          $display("FAIL rdata[%0d]: got %h expected %h", k, rdat[k], e);
        end
      end
    end
  end

  task automatic do_req(input int k, input logic [19:0] a, input logic p);
    logic [19:0] wa;
    logic [15:0] w, e;
    logic        h;
    int          edges, o0, exp_edges;
    logic        got;
    wa = {1'b0, a[19:4], a[2:0]};
    w  = model_word(wa);
    e  = p ? w : {8'h00, (a[3] ? w[15:8] : w[7:0])};
    h  = bvld[k] && (btag[k] == wa);
    exp_edges = h ? 1 : WV[k] + 1;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    o0 = oe_cnt[k];
    @(negedge clk);
    addr[k] = a; pair[k] = p; req[k] = 1'b1;
    edges = 0; got = 1'b0;
    while (!got && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (ack[k]) got = 1'b1;
    end
    req[k] = 1'b0;
    chk($sformatf("ack_latency[%0d] a=%h", k, a), edges, exp_edges);
    chk($sformatf("oe_cycles[%0d] a=%h", k, a), oe_cnt[k] - o0, h ? 0 : WV[k]);
    bvld[k] = 1'b1; btag[k] = wa; last_exp[k] = e;
    @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_ack[%0d]", tag, k), ack[k], 0);
      chk($sformatf("%s_rdata[%0d]", tag, k), rdat[k], 0);
      chk($sformatf("%s_addr[%0d]", tag, k), sa[k], 0);
      chk($sformatf("%s_strobes[%0d]", tag, k), {oe_n[k], ub_n[k], lb_n[k]}, 3'b111);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, c0, d0;
    rstn = 1'b0; done = 3'b111; req = 3'b000; pair = 3'b000;
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0; bvld[k] = 1'b0; btag[k] = '0; last_exp[k] = '0;
    end
    #23;
    chk_reset_outs("reset");
    @(negedge clk); rstn = 1'b1;

    // Pair-mode miss on preloaded word, then byte-lane hits.
    do_req(0, 20'h00022, 1'b1);
    do_req(0, 20'h0002A, 1'b0);
    do_req(0, 20'h00022, 1'b0);

    // load_done low: requests are ignored and the bus stays idle.
    done[0] = 1'b0; bvld[0] = 1'b0;
    a0 = ack_cnt[0]; c0 = oe_cnt[0]; d0 = addr_cnt[0];
    addr[0] = 20'h00022; pair[0] = 1'b1; req[0] = 1'b1;
    repeat (20) @(negedge clk);
    req[0] = 1'b0;
    chk("nodone_acks", ack_cnt[0] - a0, 0);
    chk("nodone_oe", oe_cnt[0] - c0, 0);
    chk("nodone_addr", addr_cnt[0] - d0, 0);
    done[0] = 1'b1;
    do_req(0, 20'h00022, 1'b1);

    // Abort in the second ACCESS cycle: no ack, rdata holds, buffer dropped.
    a0 = ack_cnt[0];
    @(negedge clk);
    addr[0] = 20'h00130; pair[0] = 1'b1; req[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 done[0] = 1'b0; req[0] = 1'b0; bvld[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_acks", ack_cnt[0] - a0, 0);
    chk("abort_rdata_hold", rdat[0], last_exp[0]);
    chk("abort_oe_idle", oe_n[0], 1);
    done[0] = 1'b1;
    do_req(0, 20'h00130, 1'b1);
    do_req(0, 20'h00022, 1'b0);

    // Asynchronous reset in the middle of an access.
    @(negedge clk);
    addr[0] = 20'h00450; pair[0] = 1'b1; req[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midaccess_oe_low", oe_n[0], 0);
    #2 rstn = 1'b0; req[0] = 1'b0;
    #1 chk_reset_outs("async_reset");
    for (int k = 0; k < 3; k++) bvld[k] = 1'b0;
    @(negedge clk); rstn = 1'b1;

    // WAIT_CYCLES sweep with random addresses, plus a lane-flip hit at the end.
    for (int k = 1; k < 3; k++) begin
      logic [19:0] ra;
      ra = '0;
      for (int i = 0; i < 6; i++) begin
        ra = 20'($urandom);
        do_req(k, ra, 1'($urandom_range(0, 1)));
      end
      do_req(k, ra ^ 20'h00008, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
